// File: rtl/cpu_sram_arbiter.sv
// Arbitrates the core's fetch and data ports onto one SRAM-like bus, one transaction at a time.
// Holds returned data and per-port done flags until the pipeline advances.
module cpu_sram_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_rd,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  input  logic        pipe_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        gap_q, gap_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        lat_wr_q, lat_wr_d;
  logic [3:0]  lat_wstrb_q, lat_wstrb_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;

  logic        inst_pend, data_pend, issue, pick_data, owner_live;
  logic        sel_wr;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_addr, sel_wdata;

  // Valid/ready contract: bus_req is held with stable fields until bus_addr_ok;
  // bus_data_ok is only honoured while waiting for the accepted transaction.
  always_comb begin
    inst_pend  = inst_req & ~inst_done_q;
    data_pend  = (data_rd | data_wr) & ~data_done_q;
    pick_data  = data_pend & (~inst_pend | DATA_FIRST);
    issue      = (state_q == IDLE) & ~gap_q & (inst_pend | data_pend);
    sel_wr     = pick_data & data_wr;
    sel_addr   = pick_data ? data_addr : inst_addr;
    sel_wstrb  = sel_wr ? data_wstrb : 4'b0000;
    sel_wdata  = pick_data ? data_wdata : 32'h0;
    owner_live = owner_q ? (data_rd | data_wr) : inst_req;

    inst_stall = inst_pend;
    data_stall = data_pend;
    bus_req    = ~rst & (issue | (state_q == ADDR));
    if (state_q == IDLE) begin
      bus_wr    = sel_wr;
      bus_wstrb = sel_wstrb;
      bus_addr  = sel_addr;
      bus_wdata = sel_wdata;
    end else begin
      bus_wr    = lat_wr_q;
      bus_wstrb = lat_wstrb_q;
      bus_addr  = lat_addr_q;
      bus_wdata = lat_wdata_q;
    end
    inst_rdata = inst_rdata_q;
    data_rdata = data_rdata_q;
    dbg_state  = state_q;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    gap_d        = 1'b0;
    lat_wr_d     = lat_wr_q;
    lat_wstrb_d  = lat_wstrb_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = pipe_stall ? inst_done_q : 1'b0;
    data_done_d  = pipe_stall ? data_done_q : 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          owner_d     = pick_data;
          lat_wr_d    = sel_wr;
          lat_wstrb_d = sel_wstrb;
          lat_addr_d  = sel_addr;
          lat_wdata_d = sel_wdata;
          state_d     = bus_addr_ok ? WAIT : ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (bus_data_ok) begin
          state_d = IDLE;
          // One quiet IDLE cycle lets the pipeline consume the result first.
          gap_d   = 1'b1;
          if (!owner_q) inst_rdata_d = bus_rdata;
          else if (!lat_wr_q) data_rdata_d = bus_rdata;
          if (owner_live && !owner_q) inst_done_d = 1'b1;
          if (owner_live && owner_q) data_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      gap_q        <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      lat_wr_q     <= 1'b0;
      lat_wstrb_q  <= 4'b0000;
      lat_addr_q   <= 32'h0;
      lat_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      gap_q        <= gap_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      lat_wr_q     <= lat_wr_d;
      lat_wstrb_q  <= lat_wstrb_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench for cpu_sram_arbiter: two instances (data-first and inst-first)
// share all inputs; expected values are hand-derived per cycle.
module tb_cpu_sram_arbiter;

  logic        clk, rst;
  logic        inst_req, data_rd, data_wr, pipe_stall;
  logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
  logic [3:0]  data_wstrb;
  logic        bus_addr_ok, bus_data_ok;

  logic [31:0] inst_rdata1, data_rdata1, bus_addr1, bus_wdata1;
  logic        inst_stall1, data_stall1, bus_req1, bus_wr1;
  logic [3:0]  bus_wstrb1;
  logic [1:0]  dbg_state1;

  logic [31:0] inst_rdata0, data_rdata0, bus_addr0, bus_wdata0;
  logic        inst_stall0, data_stall0, bus_req0, bus_wr0;
  logic [3:0]  bus_wstrb0;
  logic [1:0]  dbg_state0;

  int checks = 0;
  int failures = 0;

  cpu_sram_arbiter #(.DATA_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata1), .inst_stall(inst_stall1),
    .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_rdata(data_rdata1), .data_stall(data_stall1),
    .pipe_stall(pipe_stall),
    .bus_req(bus_req1), .bus_wr(bus_wr1), .bus_wstrb(bus_wstrb1), .bus_addr(bus_addr1),
    .bus_wdata(bus_wdata1), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state1)
  );

  cpu_sram_arbiter #(.DATA_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata0), .inst_stall(inst_stall0),
    .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_rdata(data_rdata0), .data_stall(data_stall0),
    .pipe_stall(pipe_stall),
    .bus_req(bus_req0), .bus_wr(bus_wr0), .bus_wstrb(bus_wstrb0), .bus_addr(bus_addr0),
    .bus_wdata(bus_wdata0), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state0)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver and checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_rd = 1'b0; data_wr = 1'b0;
    data_addr = 32'h0; data_wdata = 32'h0; data_wstrb = 4'h0; pipe_stall = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_state", dbg_state1, 0);
    chk("rst_bus_req", bus_req1, 0);
    chk("rst_inst_rdata", inst_rdata1, 32'h0);
    chk("rst_data_rdata", data_rdata1, 32'h0);
    chk("rst_inst_stall", inst_stall1, 0);
    step(); rst = 1'b0;

    // Zero-wait fetch
    step(); inst_req = 1'b1; inst_addr = 32'hBFC00000; pipe_stall = 1'b1; bus_addr_ok = 1'b1; settle();
    chk("t1_req", bus_req1, 1);
    chk("t1_addr", bus_addr1, 32'hBFC00000);
    chk("t1_wr", bus_wr1, 0);
    chk("t1_wstrb", bus_wstrb1, 4'h0);
    chk("t1_wdata", bus_wdata1, 32'h0);
    chk("t1_stall_c0", inst_stall1, 1);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h24010001; settle();
    chk("t1_stall_c1", inst_stall1, 1);
    chk("t1_req_wait", bus_req1, 0);
    chk("t1_state_wait", dbg_state1, 2);
    step(); bus_data_ok = 1'b0; settle();
    chk("t1_stall_c2", inst_stall1, 0);
    chk("t1_rdata", inst_rdata1, 32'h24010001);
    chk("t1_state_idle", dbg_state1, 0);
    chk("t1_no_reissue", bus_req1, 0);
    pipe_stall = 1'b0;
    step(); settle();
    chk("t1_done_cleared", inst_stall1, 1);
    inst_req = 1'b0; settle();

    // Contention: data-first vs inst-first
    step(); inst_req = 1'b1; inst_addr = 32'hBFC00004; data_rd = 1'b1; data_addr = 32'h80000010;
    pipe_stall = 1'b1; settle();
    chk("t2_df1_addr", bus_addr1, 32'h80000010);
    chk("t2_df0_addr", bus_addr0, 32'hBFC00004);
    chk("t2_df1_dstall", data_stall1, 1);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h11111111; settle();
    step(); bus_data_ok = 1'b0; settle();
    chk("t2_df1_dstall_c2", data_stall1, 0);
    chk("t2_df1_istall_c2", inst_stall1, 1);
    chk("t2_df1_drdata", data_rdata1, 32'h11111111);
    chk("t2_df1_gap", bus_req1, 0);
    chk("t2_df0_istall_c2", inst_stall0, 0);
    chk("t2_df0_irdata", inst_rdata0, 32'h11111111);
    step(); settle();
    chk("t2_df1_second_addr", bus_addr1, 32'hBFC00004);
    chk("t2_df1_second_req", bus_req1, 1);
    chk("t2_df0_second_addr", bus_addr0, 32'h80000010);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h22222222; settle();
    chk("t2_df1_istall_c4", inst_stall1, 1);
    step(); bus_data_ok = 1'b0; settle();
    chk("t2_df1_istall_c5", inst_stall1, 0);
    chk("t2_df1_irdata", inst_rdata1, 32'h22222222);
    chk("t2_df1_drdata_held", data_rdata1, 32'h11111111);
    chk("t2_df0_drdata", data_rdata0, 32'h22222222);
    chk("t2_df0_dstall_c5", data_stall0, 0);
    inst_req = 1'b0; data_rd = 1'b0; pipe_stall = 1'b0;

    // Store with delayed address acceptance
    step(); data_wr = 1'b1; data_addr = 32'h80000004; data_wdata = 32'hDEADBEEF; data_wstrb = 4'b0011;
    bus_addr_ok = 1'b0; pipe_stall = 1'b1; settle();
    chk("t3_req", bus_req1, 1);
    chk("t3_wr", bus_wr1, 1);
    chk("t3_addr", bus_addr1, 32'h80000004);
    chk("t3_wdata", bus_wdata1, 32'hDEADBEEF);
    chk("t3_wstrb", bus_wstrb1, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      step();
      data_addr = $urandom; data_wdata = $urandom; data_wstrb = 4'b1111;
      bus_addr_ok = (k == 2); settle();
      chk("t3_hold_req", bus_req1, 1);
      chk("t3_hold_state", dbg_state1, 1);
      chk("t3_hold_addr", bus_addr1, 32'h80000004);
      chk("t3_hold_wdata", bus_wdata1, 32'hDEADBEEF);
      chk("t3_hold_wstrb", bus_wstrb1, 4'b0011);
      chk("t3_hold_wr", bus_wr1, 1);
    end
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h33333333; settle();
    chk("t3_wait_req", bus_req1, 0);
    chk("t3_wait_stall", data_stall1, 1);
    step(); bus_data_ok = 1'b0; settle();
    chk("t3_done", data_stall1, 0);
    chk("t3_rdata_kept", data_rdata1, 32'h11111111);
    data_wr = 1'b0; pipe_stall = 1'b0; bus_addr_ok = 1'b1;

    // Flushed fetch
    step(); inst_req = 1'b1; inst_addr = 32'hBFC00008; pipe_stall = 1'b1; settle();
    chk("t4_req", bus_req1, 1);
    chk("t4_addr", bus_addr1, 32'hBFC00008);
    step(); inst_req = 1'b0; settle();
    chk("t4_state_wait", dbg_state1, 2);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h44444444; settle();
    step(); bus_data_ok = 1'b0; settle();
    chk("t4_rdata_written", inst_rdata1, 32'h44444444);
    inst_req = 1'b1; inst_addr = 32'hBFC0000C; settle();
    chk("t4_not_done", inst_stall1, 1);
    chk("t4_gap", bus_req1, 0);
    step(); settle();
    chk("t4_next_req", bus_req1, 1);
    chk("t4_next_addr", bus_addr1, 32'hBFC0000C);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h55555555; settle();
    step(); bus_data_ok = 1'b0; data_rd = 1'b1; data_addr = 32'h80000020; settle();
    chk("t4_next_done", inst_stall1, 0);
    chk("t4_next_rdata", inst_rdata1, 32'h55555555);
    chk("t5_dstall", data_stall1, 1);
    step(); settle();
    chk("t5_load_req", bus_req1, 1);
    chk("t5_load_addr", bus_addr1, 32'h80000020);
    chk("t5_load_wstrb", bus_wstrb1, 4'h0);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h66666666; settle();

    // Pipeline hold with both ports done; stray data_ok in IDLE
    for (int k = 0; k < 4; k++) begin
      step(); bus_data_ok = k[0]; bus_rdata = $urandom; settle();
      chk("t5_hold_req", bus_req1, 0);
      chk("t5_hold_irdata", inst_rdata1, 32'h55555555);
      chk("t5_hold_drdata", data_rdata1, 32'h66666666);
      chk("t5_hold_istall", inst_stall1, 0);
      chk("t5_hold_dstall", data_stall1, 0);
    end
    step(); bus_data_ok = 1'b0; pipe_stall = 1'b0; inst_addr = 32'hBFC00010; data_rd = 1'b0; settle();
    chk("t5_release_stall", inst_stall1, 0);
    step(); pipe_stall = 1'b1; settle();
    chk("t5_new_stall", inst_stall1, 1);
    chk("t5_new_req", bus_req1, 1);
    chk("t5_new_addr", bus_addr1, 32'hBFC00010);

    // Asynchronous reset while waiting for data
    step(); settle();
    chk("t6_pre_state", dbg_state1, 2);
    rst = 1'b1; #1;
    chk("t6_rst_state", dbg_state1, 0);
    chk("t6_rst_req", bus_req1, 0);
    chk("t6_rst_irdata", inst_rdata1, 32'h0);
    chk("t6_rst_drdata", data_rdata1, 32'h0);
    chk("t6_rst_istall", inst_stall1, 1);
    rst = 1'b0; inst_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h77777777; settle();
    step(); bus_data_ok = 1'b0; settle();
    chk("t6_stale_state", dbg_state1, 0);
    chk("t6_stale_irdata", inst_rdata1, 32'h0);
    chk("t6_stale_drdata", data_rdata1, 32'h0);
    chk("t6_stale_req", bus_req1, 0);
    chk("t6_stale_istall", inst_stall1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
Shares one SRAM-like bus between the CPU's instruction-fetch port (pcF/instrF) and data port (memreadM/memwriteM, aluoutM, writedataM, selectM, readdataM). Sits between the mips core and the memory/bridge. Serialises requests, one transaction outstanding at a time. Generates per-port stall signals for the hazard unit and holds returned data until the pipeline advances.

Parameters:
DATA_FIRST, 1, 1 = data port wins simultaneous arbitration, 0 = instruction port wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst_req  in  1  fetch request (instruction fetch valid)
inst_addr  in  32  fetch address (pcF)
inst_rdata  out  32  buffered instruction
inst_stall  out  1  fetch not yet satisfied
data_rd  in  1  load request (memreadM)
data_wr  in  1  store request (memwriteM)
data_addr  in  32  data address (aluoutM)
data_wdata  in  32  store data (writedataM)
data_wstrb  in  4  byte enables (selectM)
data_rdata  out  32  buffered load data
data_stall  out  1  data access not yet satisfied
pipe_stall  in  1  global pipeline stall from the hazard unit (includes both stalls above)
bus_req  out  1  bus request
bus_wr  out  1  1 = write
bus_wstrb  out  4  byte enables; 4'b0000 on reads
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_addr_ok  in  1  address accepted
bus_data_ok  in  1  read data valid / write done
bus_rdata  in  32  read data

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - inst_done = data_done = 0.
  - inst_rdata = data_rdata = 32'h0.
  - bus_req = 0.
  - Stalls follow their combinational equations.
- Pending conditions:
  - inst_pend = inst_req & ~inst_done.
  - data_pend = (data_rd | data_wr) & ~data_done.
- Stall outputs (combinational): inst_stall = inst_pend; data_stall = data_pend.
- FSM states: IDLE, ADDR, WAIT. Register owner holds 0 = inst, 1 = data.
- IDLE:
  - If any pend: select the source (DATA_FIRST breaks ties) and drive bus_req = 1 with that source's fields in the same cycle.
  - Latch owner and the request fields into registers.
  - bus_addr_ok = 1: go to WAIT. Otherwise go to ADDR.
- ADDR:
  - bus_req = 1, driven from the latched fields. Owner is locked and the fields stay stable even if the source changes or deasserts.
  - Go to WAIT on bus_addr_ok.
- WAIT:
  - bus_req = 0.
  - On bus_data_ok, go to IDLE. If the owner's request is still asserted, set owner_done.
  - A data read, or any inst fetch, also captures bus_rdata into the owner's rdata register.
  - Writes leave data_rdata unchanged.
- Dropped requests: if the owner's request is deasserted at data_ok (flush), the result is discarded and no done flag is set.
- Done-flag clear: on any edge with pipe_stall = 0, clear inst_done and data_done. A set on the same edge wins over the clear.
- Ignored inputs: bus_data_ok in IDLE or ADDR, and bus_addr_ok in WAIT, have no effect.
- Latency: with a zero-wait bus (addr_ok same cycle, data_ok next cycle), an uncontended access stalls 2 cycles. Back-to-back transactions have a 1-cycle IDLE gap.
- Contention: with a simultaneous inst and data miss and DATA_FIRST = 1, the data access is serviced first. inst_stall stays high throughout.
- Output mux: bus_wr = latched (data & data_wr). bus_wstrb and bus_wdata come from the latched data fields; bus_wdata = 0 for inst.
- Reset mid-transaction: returns to IDLE immediately. Late data_ok is ignored.

Test Plan:
1. Zero-wait fetch: inst_req = 1, addr 32'hBFC00000, addr_ok in cycle 1, data_ok + rdata 32'h24010001 in cycle 2 → inst_stall high for 2 cycles, inst_rdata = 32'h24010001, inst_done clears when pipe_stall = 0.
2. Contention: inst_req plus data_rd at 32'h80000010 in the same cycle, DATA_FIRST = 1 → bus issues the data read first, then the fetch. data_stall drops after 2 cycles, inst_stall after 5. Repeat with DATA_FIRST = 0 → order reversed.
3. Store: data_wr, addr 32'h80000004, wdata 32'hDEADBEEF, wstrb 4'b0011 → bus_wr = 1 with exact fields. data_rdata unchanged. addr_ok delayed 3 cycles → fields held stable.
4. Flush: fetch in WAIT, inst_req dropped before data_ok → inst_done stays 0, inst_rdata still written, the next request is issued normally.
5. Pipe hold: both done, pipe_stall = 1 for 4 cycles → no new bus requests and the rdata registers are held. pipe_stall falls → flags clear and the new fetch is issued.
6. Async reset asserted in WAIT → state IDLE, bus_req = 0 without a clock edge. A stale data_ok afterwards changes nothing.
